// File: rtl/mux_4_1_rr_scheduler_pkg.sv
// Shared types and the winner-search function for the 4-requester scheduler.
package mux_4_1_rr_scheduler_pkg;

   localparam int N_REQ = 4;

   typedef logic [1:0] req_id_t;

   typedef enum logic {EMPTY, FULL} out_state_t;

   // Pointer value after reset; the search starts at ptr + 1, so requester 0 wins first.
   localparam req_id_t PTR_RESET = 2'd3;

   // Returns the first set bit of valid, searching upward from ptr + 1 and
   // wrapping 3 -> 0. The loop runs from the farthest candidate back to the
   // nearest, so the nearest set bit is the last one written. With ptr held at
   // PTR_RESET this becomes a plain lowest-index-wins priority search.
   function automatic req_id_t next_winner(input logic [N_REQ-1:0] valid,
                                           input req_id_t          ptr);
      req_id_t win;
      req_id_t idx;
      win = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = ptr + req_id_t'(k);
         if (valid[idx]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/mux_4_1_rr_scheduler_data_mux.sv
// WIDTH-parameterized combinational 4:1 word mux; sel picks word sel of in_data.
module data_mux_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic [4*WIDTH-1:0] in_data,
   input  logic [1:0]         sel,
   output logic [WIDTH-1:0]   out_data
);

   // Select one packed word.
   always_comb begin
      out_data = in_data[0 +: WIDTH];
      case (sel)
         2'd0: out_data = in_data[0*WIDTH +: WIDTH];
         2'd1: out_data = in_data[1*WIDTH +: WIDTH];
         2'd2: out_data = in_data[2*WIDTH +: WIDTH];
         2'd3: out_data = in_data[3*WIDTH +: WIDTH];
         default: out_data = in_data[0 +: WIDTH];
      endcase
   end

endmodule

// File: rtl/mux_4_1_rr_scheduler.sv
// Four-requester scheduler owning the select of a 4:1 data mux, with a
// one-entry valid/ready output register.
// Build option: MUX_4_1_RR_SCHED_ROUND_ROBIN_EN selects round-robin arbitration
// (pointer register present); without it, the lowest requesting index wins and
// no pointer register exists.
//
// state | meaning
// EMPTY | output register holds nothing, out_valid = 0
// FULL  | output register holds a word, out_valid = 1
module mux_4_1_rr_scheduler
   import mux_4_1_rr_scheduler_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           in_valid,
   input  logic [4*WIDTH-1:0]   in_data,
   output logic [3:0]           in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [1:0]           out_id
);

   out_state_t       state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   req_id_t          out_id_q, out_id_d;
   logic [WIDTH-1:0] mux_word;
   req_id_t          grant;
   req_id_t          ptr_cur;
   logic             can_accept;
   logic             accept;

`ifdef MUX_4_1_RR_SCHED_ROUND_ROBIN_EN
   req_id_t ptr_q, ptr_d;

   assign ptr_cur = ptr_q;

   // Pointer follows the last winner; it moves only on an accept.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = grant;
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= PTR_RESET;
      else     ptr_q <= ptr_d;
   end
`else
   assign ptr_cur = PTR_RESET;
`endif

   // Winner search; depends only on in_valid and the pointer, never on data.
   always_comb begin
      grant = next_winner(in_valid, ptr_cur);
   end

   // Handshake: the register can take a word when empty or when draining now.
   always_comb begin
      can_accept = (state_q == EMPTY) || out_ready;
      accept     = can_accept && (|in_valid) && !rst;
      in_ready   = accept ? (4'b0001 << grant) : 4'b0000;
   end

   data_mux_4_1 #(.WIDTH(WIDTH)) u_data_mux (
      .in_data  (in_data),
      .sel      (grant),
      .out_data (mux_word)
   );

   // Next-state and output-register load logic.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (accept)         state_d = FULL;
            else if (out_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
      if (accept) begin
         out_data_d = mux_word;
         out_id_d   = grant;
      end
   end

   // State and output registers; reset drops any held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         out_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux_4_1_rr_scheduler.sv
// Directed, table-driven bench for mux_4_1_rr_scheduler (WIDTH = 4).
module tb_mux_4_1_rr_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_id;

   int n_vec;
   int n_err;

   typedef struct {
      logic        rst;
      logic [3:0]  iv;
      logic [15:0] din;
      logic        ordy;
      logic [3:0]  e_ir;
      logic        e_ov;
      logic [3:0]  e_d;
      logic [1:0]  e_id;
   } vec_t;

   vec_t vq[$];

   mux_4_1_rr_scheduler #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic [3:0] iv, input logic [15:0] din,
                               input logic ordy, input logic [3:0] e_ir, input logic e_ov,
                               input logic [3:0] e_d, input logic [1:0] e_id);
      vec_t v;
      v.rst = r; v.iv = iv; v.din = din; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_id = e_id;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input int row, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   // Words: w0 = 1, w1 = A, w2 = 5, w3 = 3 (D0); D1 changes w2 to 9.
   localparam logic [15:0] D0 = 16'h35A1;
   localparam logic [15:0] D1 = 16'h39A1;

   initial begin
      logic [15:0] din_k;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; in_valid = 4'b0; in_data = D0; out_ready = 1'b0;

      // reset state
      add(1, 4'b1111, D0, 1, 4'b0000, 0, 4'h0, 2'd0);
      add(1, 4'b1111, D0, 1, 4'b0000, 0, 4'h0, 2'd0);
      add(0, 4'b0000, D0, 1, 4'b0000, 0, 4'h0, 2'd0);
`ifdef MUX_4_1_RR_SCHED_ROUND_ROBIN_EN
      // all requesting: rotation 0,1,2,3,0
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      add(0, 4'b1111, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
      add(0, 4'b1111, D0, 1, 4'b0100, 1, 4'h5, 2'd2);
      add(0, 4'b1111, D0, 1, 4'b1000, 1, 4'h3, 2'd3);
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      // sparse requests alternate 1 / 3
      add(1, 4'b0000, D0, 0, 4'b0000, 0, 4'h0, 2'd0);
      add(0, 4'b1010, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
      add(0, 4'b1010, D0, 1, 4'b1000, 1, 4'h3, 2'd3);
      add(0, 4'b1010, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
      add(0, 4'b1010, D0, 1, 4'b1000, 1, 4'h3, 2'd3);
`else
      // fixed priority: requester 0 always wins
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);
      // sparse requests: requester 1 always wins
      add(1, 4'b0000, D0, 0, 4'b0000, 0, 4'h0, 2'd0);
      add(0, 4'b1010, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
      add(0, 4'b1010, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
      add(0, 4'b1010, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
      add(0, 4'b1010, D0, 1, 4'b0010, 1, 4'hA, 2'd1);
`endif
      // single request with a 3-cycle stall, then immediate re-accept
      add(1, 4'b0000, D0, 0, 4'b0000, 0, 4'h0, 2'd0);
      add(0, 4'b0100, D0, 1, 4'b0100, 1, 4'h5, 2'd2);
      add(0, 4'b0100, D0, 0, 4'b0000, 1, 4'h5, 2'd2);
      add(0, 4'b0100, D1, 0, 4'b0000, 1, 4'h5, 2'd2);
      add(0, 4'b0100, D1, 0, 4'b0000, 1, 4'h5, 2'd2);
      add(0, 4'b0100, D1, 1, 4'b0100, 1, 4'h9, 2'd2);
      // drain to empty, data held
      add(0, 4'b0000, D1, 1, 4'b0000, 0, 4'h9, 2'd2);
      // empty accepts regardless of out_ready
      add(0, 4'b0001, D1, 0, 4'b0001, 1, 4'h1, 2'd0);
      // reset while full with id 2 drops the word
      add(0, 4'b0100, D1, 1, 4'b0100, 1, 4'h9, 2'd2);
      add(1, 4'b0100, D1, 0, 4'b0000, 0, 4'h0, 2'd0);
      add(0, 4'b1111, D0, 1, 4'b0001, 1, 4'h1, 2'd0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst = vq[i].rst; in_valid = vq[i].iv; in_data = vq[i].din; out_ready = vq[i].ordy;
         #1;
         chk("in_ready", i, {12'h0, in_ready}, {12'h0, vq[i].e_ir});
         @(posedge clk);
         #1;
         chk("out_valid", i, {15'h0, out_valid}, {15'h0, vq[i].e_ov});
         chk("out_data", i, {12'h0, out_data}, {12'h0, vq[i].e_d});
         chk("out_id", i, {14'h0, out_id}, {14'h0, vq[i].e_id});
      end

      // back-to-back drain and refill with changing data: no bubble
      @(negedge clk);
      rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rst = 1'b0; in_valid = 4'b0001;
         din_k = {12'h35A, 4'(k + 6)};
         in_data = din_k;
         #1;
         chk("b2b_in_ready", 100 + k, {12'h0, in_ready}, 16'h0001);
         @(posedge clk);
         #1;
         chk("b2b_out_valid", 100 + k, {15'h0, out_valid}, 16'h0001);
         chk("b2b_out_data", 100 + k, {12'h0, out_data}, 16'(k + 6));
      end
      // stalled register ignores input data changes
      @(negedge clk);
      out_ready = 1'b0; in_data = 16'h35AF;
      #1;
      chk("stall_in_ready", 200, {12'h0, in_ready}, 16'h0000);
      @(posedge clk);
      #1;
      chk("stall_out_data", 200, {12'h0, out_data}, 16'h0009);
      chk("stall_out_id", 200, {14'h0, out_id}, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
